// File: rtl/sd_bitstream_prefetch_pkg.sv
// Shared definitions for the SD bitstream prefetcher: sector geometry and
// the write-side state encoding used by sd_bitstream_prefetch.
package sd_bitstream_prefetch_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_LOG2  = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/sd_bitstream_prefetch_ram.sv
// Single-port synchronous RAM backing the sector banks. A write cycle
// stores wdata; every cycle registers the addressed word (read-first).
module sd_bitstream_prefetch_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage array plus registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sd_bitstream_prefetch.sv
// Sector prefetcher between the FAT32 file reader and the H.264 bitstream
// parser. Sectors land in a ring of 512-byte banks and are served one byte
// per pop with one cycle of latency.
// Optional feature: define PREFETCH_WATCHDOG_EN to add an idle watchdog that
// closes out the fill and raises watchdog_to when the reader stalls.
module sd_bitstream_prefetch
    import sd_bitstream_prefetch_pkg::*;
#(
    parameter int          BANK_LOG2       = 2,
    parameter int          END_QUIET       = 16,
    parameter logic [23:0] WATCHDOG_CYCLES = 24'hffffff
) (
    input  logic               clk,
    input  logic               rst,
    output logic               file_read_req,
    input  logic [7:0]         file_data,
    input  logic               file_data_valid,
    input  logic               file_reach_end,
    input  logic               bs_rd_req,
    output logic [7:0]         bs_data,
    output logic               bs_data_valid,
    output logic               bs_avail,
    output logic               bs_eof,
    output logic [BANK_LOG2:0] bank_level,
    output logic               watchdog_to
);

    localparam int BANKS  = 1 << BANK_LOG2;
    localparam int ADDR_W = BANK_LOG2 + SECTOR_LOG2;
    localparam int QW     = $clog2(END_QUIET + 1);

    localparam logic [BANK_LOG2-1:0]   BANK_ONE   = 1;
    localparam logic [BANK_LOG2:0]     LVL_ONE    = 1;
    localparam logic [BANK_LOG2:0]     LVL_FULL   = (BANK_LOG2 + 1)'(BANKS);
    localparam logic [SECTOR_LOG2-1:0] LAST_OFF   = SECTOR_LOG2'(SECTOR_BYTES - 1);
    localparam logic [QW-1:0]          QUIET_LAST = QW'(END_QUIET - 1);
    localparam logic [QW-1:0]          QUIET_ONE  = 1;

    fill_state_t            state_q, state_d;
    logic [BANK_LOG2-1:0]   wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [SECTOR_LOG2-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
    logic [9:0]             len_q [BANKS];
    logic [9:0]             len_d [BANKS];
    logic [BANK_LOG2:0]     bank_level_q, bank_level_d;
    logic [QW-1:0]          quiet_q, quiet_d;
    logic                   end_seen_q, end_seen_d;
    logic                   eof_q, eof_d;
    logic                   dvalid_q, dvalid_d;

    logic                   write_en, pop, release_bank, commit, close_fill, wdog_hit;
    logic [9:0]             commit_len, cur_len;
    logic [ADDR_W-1:0]      ram_addr;
    logic [7:0]             ram_rdata;

    // The RAM port is taken by any incoming byte, so pops are held off that cycle
    assign write_en     = file_data_valid && (state_q == S_REQ || state_q == S_FILL);
    assign bs_avail     = (bank_level_q != '0) && !write_en;
    assign pop          = bs_rd_req && bs_avail;
    assign cur_len      = len_q[rd_bank_q];
    assign release_bank = pop && ({1'b0, rd_off_q} == cur_len - 10'd1);
    assign ram_addr     = write_en ? {wr_bank_q, wr_off_q} : {rd_bank_q, rd_off_q};

`ifdef PREFETCH_WATCHDOG_EN
    logic [23:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_to_q, wdog_to_d;

    // Count cycles the reader leaves us waiting; hitting the limit ends the file
    always_comb begin
        wdog_cnt_d = '0;
        wdog_hit   = 1'b0;
        wdog_to_d  = wdog_to_q;
        if ((state_q == S_REQ || state_q == S_FILL) && !file_data_valid) begin
            if (wdog_cnt_q == WATCHDOG_CYCLES - 24'd1) begin
                wdog_hit  = 1'b1;
                wdog_to_d = 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + 24'd1;
            end
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_to_q  <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_to_q  <= wdog_to_d;
        end
    end

    assign watchdog_to = wdog_to_q;
`else
    assign wdog_hit    = 1'b0;
    // Flag is tied low; the limit is folded in so the parameter stays referenced
    assign watchdog_to = 1'b0 & (WATCHDOG_CYCLES == 24'd0);
`endif

    // Write-side FSM: request, fill and commit banks, close out at end of file
    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        wr_off_d   = wr_off_q;
        // A watchdog timeout is treated as end of file so bs_eof can follow
        end_seen_d = end_seen_q | file_reach_end | wdog_hit;
        quiet_d    = '0;
        commit     = 1'b0;
        commit_len = '0;
        close_fill = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (end_seen_d) begin
                    state_d = S_DONE;
                end else if (bank_level_q < LVL_FULL) begin
                    state_d = S_REQ;
                end
            end
            S_REQ, S_FILL: begin
                if (file_data_valid) begin
                    if (wr_off_q == LAST_OFF) begin
                        commit     = 1'b1;
                        commit_len = 10'(SECTOR_BYTES);
                        wr_off_d   = '0;
                        wr_bank_d  = wr_bank_q + BANK_ONE;
                        state_d    = S_IDLE;
                    end else begin
                        wr_off_d = wr_off_q + 9'd1;
                        state_d  = S_FILL;
                    end
                end else begin
                    if (end_seen_q) begin
                        if (quiet_q == QUIET_LAST) begin
                            close_fill = 1'b1;
                        end else begin
                            quiet_d = quiet_q + QUIET_ONE;
                        end
                    end
                    if (wdog_hit) begin
                        close_fill = 1'b1;
                    end
                end
                if (close_fill) begin
                    if (wr_off_q != '0) begin
                        commit     = 1'b1;
                        commit_len = {1'b0, wr_off_q};
                        wr_off_d   = '0;
                        wr_bank_d  = wr_bank_q + BANK_ONE;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read pointers, bank lengths, occupancy and the registered output flags
    always_comb begin
        rd_bank_d = rd_bank_q;
        rd_off_d  = rd_off_q;
        len_d     = len_q;
        if (pop) begin
            if (release_bank) begin
                rd_off_d  = '0;
                rd_bank_d = rd_bank_q + BANK_ONE;
            end else begin
                rd_off_d = rd_off_q + 9'd1;
            end
        end
        if (commit) begin
            len_d[wr_bank_q] = commit_len;
        end
        case ({commit, release_bank})
            2'b10:   bank_level_d = bank_level_q + LVL_ONE;
            2'b01:   bank_level_d = bank_level_q - LVL_ONE;
            default: bank_level_d = bank_level_q;
        endcase
        dvalid_d = pop;
        eof_d    = eof_q | (end_seen_q && state_q == S_DONE && bank_level_q == '0);
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_bank_q    <= '0;
            wr_off_q     <= '0;
            rd_bank_q    <= '0;
            rd_off_q     <= '0;
            len_q        <= '{default: '0};
            bank_level_q <= '0;
            quiet_q      <= '0;
            end_seen_q   <= 1'b0;
            eof_q        <= 1'b0;
            dvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            wr_off_q     <= wr_off_d;
            rd_bank_q    <= rd_bank_d;
            rd_off_q     <= rd_off_d;
            len_q        <= len_d;
            bank_level_q <= bank_level_d;
            quiet_q      <= quiet_d;
            end_seen_q   <= end_seen_d;
            eof_q        <= eof_d;
            dvalid_q     <= dvalid_d;
        end
    end

    sd_bitstream_prefetch_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(8)
    ) u_ram (
        .clk  (clk),
        .we   (write_en),
        .addr (ram_addr),
        .wdata(file_data),
        .rdata(ram_rdata)
    );

    assign file_read_req = (state_q == S_REQ);
    assign bs_data       = dvalid_q ? ram_rdata : 8'd0;
    assign bs_data_valid = dvalid_q;
    assign bs_eof        = eof_q;
    assign bank_level    = bank_level_q;

endmodule

// File: tb/tb_sd_bitstream_prefetch.sv
// Directed bench for sd_bitstream_prefetch: a scripted file reader feeds
// sectors on request, pops are checked in order against a byte queue.
// With PREFETCH_WATCHDOG_EN defined the watchdog timeout is exercised too.
module tb_sd_bitstream_prefetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       file_read_req;
    logic [7:0] file_data;
    logic       file_data_valid;
    logic       file_reach_end;
    logic       bs_rd_req;
    logic [7:0] bs_data;
    logic       bs_data_valid;
    logic       bs_avail;
    logic       bs_eof;
    logic [2:0] bank_level;
    logic       watchdog_to;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] expQ[$];
    logic       popPending = 1'b0;
    logic [7:0] expData = 8'd0;
    int         reqCount = 0;
    logic       reqPrev = 1'b0;
    int         popCount = 0;
    logic       fileEnd = 1'b0;
    int         n;

    always #5 clk = ~clk;

    sd_bitstream_prefetch #(
        .BANK_LOG2(2),
        .END_QUIET(16),
        .WATCHDOG_CYCLES(24'd100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .file_read_req  (file_read_req),
        .file_data      (file_data),
        .file_data_valid(file_data_valid),
        .file_reach_end (file_reach_end),
        .bs_rd_req      (bs_rd_req),
        .bs_data        (bs_data),
        .bs_data_valid  (bs_data_valid),
        .bs_avail       (bs_avail),
        .bs_eof         (bs_eof),
        .bank_level     (bank_level),
        .watchdog_to    (watchdog_to)
    );

    // Byte content of sector 'sec' at offset 'idx' as delivered by the reader
    function automatic logic [7:0] pattern(input int sec, input int idx);
        return 8'((idx + (idx >> 8) * 101 + sec * 29) & 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Verify the read port against the pop issued in the previous cycle
    task automatic checkOutput();
        if (popPending) begin
            check("pop_valid", {31'd0, bs_data_valid}, 32'd1);
            check("pop_data", {24'd0, bs_data}, {24'd0, expData});
        end else begin
            check("no_pop_valid", {31'd0, bs_data_valid}, 32'd0);
        end
    endtask

    // One clock cycle: sample at the falling edge, then drive the next inputs
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rd);
        @(negedge clk);
        checkOutput();
        if (file_read_req && !reqPrev) reqCount++;
        reqPrev         = file_read_req;
        file_data_valid = v;
        file_data       = d;
        file_reach_end  = fileEnd;
        bs_rd_req       = rd;
        if (v) expQ.push_back(d);
        #1;
        popPending = rd && bs_avail;
        if (popPending) begin
            popCount++;
            if (expQ.size() == 0) begin
                check("pop_with_nothing_committed", {31'd0, bs_avail}, 32'd0);
                popPending = 1'b0;
            end else begin
                expData = expQ.pop_front();
            end
        end
    endtask

    // Wait for a request, then stream nbytes of sector 'sec' (optional idle gaps)
    task automatic runSector(input int sec, input int nbytes, input logic gap, input logic popWhile);
        int waitN = 0;
        while (!file_read_req && waitN < 2000) begin
            applyStimulus(1'b0, 8'd0, popWhile);
            waitN++;
        end
        check("req_seen", {31'd0, file_read_req}, 32'd1);
        for (int i = 0; i < nbytes; i++) begin
            applyStimulus(1'b1, pattern(sec, i), popWhile);
            if (gap) applyStimulus(1'b0, 8'd0, popWhile);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst             = 1'b1;
        file_data_valid = 1'b0;
        file_data       = 8'd0;
        file_reach_end  = 1'b0;
        bs_rd_req       = 1'b0;
        fileEnd         = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        popPending = 1'b0;
        reqPrev    = 1'b0;
        reqCount   = 0;
        popCount   = 0;
        expQ.delete();
    endtask

    initial begin
        rst             = 1'b1;
        file_data       = 8'd0;
        file_data_valid = 1'b0;
        file_reach_end  = 1'b0;
        bs_rd_req       = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req", {31'd0, file_read_req}, 32'd0);
        check("rst_data", {24'd0, bs_data}, 32'd0);
        check("rst_dvalid", {31'd0, bs_data_valid}, 32'd0);
        check("rst_avail", {31'd0, bs_avail}, 32'd0);
        check("rst_eof", {31'd0, bs_eof}, 32'd0);
        check("rst_level", {29'd0, bank_level}, 32'd0);
        check("rst_wdog", {31'd0, watchdog_to}, 32'd0);
        rst = 1'b0;

        // Three full sectors, no pops
        for (int s = 0; s < 3; s++) runSector(s, 512, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        check("level_after_3", {29'd0, bank_level}, 32'd3);
        check("req_count_3", reqCount, 32'd3);
        check("avail_after_3", {31'd0, bs_avail}, 32'd1);

        // Fourth sector fills the ring; requests must stop
        runSector(3, 512, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, 8'd0, 1'b0);
        check("req_count_full", reqCount, 32'd4);
        check("req_low_when_full", {31'd0, file_read_req}, 32'd0);
        check("level_full", {29'd0, bank_level}, 32'd4);

        // Drain exactly one bank; the next request follows one cycle after release
        repeat (512) applyStimulus(1'b0, 8'd0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0);
        check("level_after_release", {29'd0, bank_level}, 32'd3);
        applyStimulus(1'b0, 8'd0, 1'b0);
        check("req_after_release", {31'd0, file_read_req}, 32'd1);
        check("req_count_5", reqCount, 32'd5);

        // Fill and pop concurrently; writes steal the port on their cycles
        runSector(4, 512, 1'b1, 1'b1);
        runSector(5, 512, 1'b1, 1'b1);
        n = 0;
        while (expQ.size() > 0 && n < 5000) begin
            applyStimulus(1'b0, 8'd0, 1'b1);
            n++;
        end
        applyStimulus(1'b0, 8'd0, 1'b0);
        check("drain_queue_empty", expQ.size(), 32'd0);
        check("drain_level", {29'd0, bank_level}, 32'd0);
        check("drain_avail", {31'd0, bs_avail}, 32'd0);
        check("req_count_7", reqCount, 32'd7);

        // 716-byte file: one full bank plus a 204-byte tail closed by the quiet period
        popCount = 0;
        runSector(6, 512, 1'b0, 1'b0);
        runSector(7, 204, 1'b0, 1'b0);
        fileEnd = 1'b1;
        repeat (30) applyStimulus(1'b0, 8'd0, 1'b0);
        check("eof_level", {29'd0, bank_level}, 32'd2);
        check("eof_not_yet", {31'd0, bs_eof}, 32'd0);
        check("eof_req_low", {31'd0, file_read_req}, 32'd0);
        check("eof_req_count", reqCount, 32'd8);
        n = 0;
        while (!bs_eof && n < 3000) begin
            applyStimulus(1'b0, 8'd0, 1'b1);
            n++;
        end
        check("eof_set", {31'd0, bs_eof}, 32'd1);
        check("eof_pops", popCount, 32'd716);
        check("eof_avail", {31'd0, bs_avail}, 32'd0);
        repeat (40) applyStimulus(1'b0, 8'd0, 1'b1);
        check("eof_no_more_req", reqCount, 32'd8);
        check("eof_sticky", {31'd0, bs_eof}, 32'd1);

        // Reset in the middle of the third sector
        pulseReset();
        runSector(0, 512, 1'b0, 1'b0);
        runSector(1, 512, 1'b0, 1'b0);
        runSector(2, 300, 1'b0, 1'b0);
        @(negedge clk);
        rst             = 1'b1;
        file_data_valid = 1'b0;
        bs_rd_req       = 1'b0;
        @(negedge clk);
        check("midrst_level", {29'd0, bank_level}, 32'd0);
        check("midrst_req", {31'd0, file_read_req}, 32'd0);
        check("midrst_avail", {31'd0, bs_avail}, 32'd0);
        check("midrst_dvalid", {31'd0, bs_data_valid}, 32'd0);
        check("midrst_eof", {31'd0, bs_eof}, 32'd0);
        rst        = 1'b0;
        popPending = 1'b0;
        reqPrev    = 1'b0;
        reqCount   = 0;
        expQ.delete();
        runSector(9, 512, 1'b0, 1'b0);
        check("restart_req_count", reqCount, 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0);
        check("restart_first_byte", {24'd0, bs_data}, {24'd0, pattern(9, 0)});

`ifdef PREFETCH_WATCHDOG_EN
        // Reader stalls after 50 bytes; timeout after 100 idle cycles
        pulseReset();
        runSector(20, 50, 1'b0, 1'b0);
        n = 0;
        while (!watchdog_to && n < 300) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            n++;
        end
        check("wdog_set", {31'd0, watchdog_to}, 32'd1);
        check("wdog_cycle", n, 32'd101);
        popCount = 0;
        n = 0;
        while (!bs_eof && n < 500) begin
            applyStimulus(1'b0, 8'd0, 1'b1);
            n++;
        end
        check("wdog_pops", popCount, 32'd50);
        check("wdog_eof", {31'd0, bs_eof}, 32'd1);
`else
        check("wdog_tied_low", {31'd0, watchdog_to}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
